external_block_model: RTL

- Synthesizable, parametrised responder for external register blocks in regblock test benches; successor to the single-register external responder.
- Models a DEPTH-word array behind one external strobe interface, with a per-request pseudo-random ack latency from an LFSR in place of a behavioural random delay.
- Sits on the hwif external-block port of the DUT; one outstanding transaction at a time.

---
 rtl/external_block_model_pkg.sv | 18 +
 rtl/ext_lfsr16.sv | 25 ++
 rtl/external_block_model.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/external_block_model_pkg.sv
// Shared types and helpers for the external register-block responder model.
package external_block_model_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    function automatic logic [3:0] calc_delay(
        input logic [15:0] lfsr,
        input int unsigned min_d,
        input int unsigned max_d
    );
        int unsigned span;
        span = max_d - min_d + 1;
        return 4'(min_d + (32'(lfsr[7:0]) % span));
    endfunction

endpackage

// File: rtl/ext_lfsr16.sv
// 16-bit Galois LFSR, free-running, loaded with seed while in reset.
module ext_lfsr16
    import external_block_model_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] out
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) lfsr_d = lfsr_d ^ LFSR_MASK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= seed;
        else     lfsr_q <= lfsr_d;
    end

    assign out = lfsr_q;

endmodule

// File: rtl/external_block_model.sv
// DEPTH-word external block responder with LFSR-driven ack latency.
// EXTERNAL_BLOCK_MODEL_ERR_EN adds rd_err/wr_err outputs and ERR_MASK.
module external_block_model
    import external_block_model_pkg::*;
#(
    parameter int          WIDTH      = 32,
    parameter int          DEPTH      = 16,
    parameter int          ADDR_WIDTH = 4,
    parameter int          MIN_DELAY  = 0,
    parameter int          MAX_DELAY  = 3,
    parameter logic [15:0] SEED       = 16'hACE1
`ifdef EXTERNAL_BLOCK_MODEL_ERR_EN
    ,
    parameter logic [DEPTH-1:0] ERR_MASK = '0
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  req_is_wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [WIDTH-1:0]      wr_biten,
    output logic                  rd_ack,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  wr_ack,
    output logic                  overrun
`ifdef EXTERNAL_BLOCK_MODEL_ERR_EN
    ,
    output logic                  rd_err,
    output logic                  wr_err
`endif
);

    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  is_wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WIDTH-1:0]      data_q, biten_q;
    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic                  rd_ack_q, wr_ack_q, overrun_q;
    logic [WIDTH-1:0]      rd_data_q;
    logic [15:0]           lfsr_w;
    logic [3:0]            delay_w;
    logic [IDXW-1:0]       idx;
    logic                  in_range, masked, wr_ok;

    ext_lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (SEED),
        .out  (lfsr_w)
    );

    assign delay_w  = calc_delay(lfsr_w, MIN_DELAY, MAX_DELAY);
    assign idx      = addr_q[IDXW-1:0];
    assign in_range = 32'(addr_q) < 32'(DEPTH);
`ifdef EXTERNAL_BLOCK_MODEL_ERR_EN
    assign masked   = in_range && ERR_MASK[idx];
`else
    assign masked   = 1'b0;
`endif
    assign wr_ok    = in_range && !masked;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (req) begin
                cnt_d   = delay_w;
                state_d = (delay_w != 4'd0) ? WAIT : ACK;
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            biten_q   <= '0;
            rd_ack_q  <= 1'b0;
            wr_ack_q  <= 1'b0;
            rd_data_q <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_ack_q  <= 1'b0;
            wr_ack_q  <= 1'b0;
            rd_data_q <= '0;
            if (req && state_q != IDLE) overrun_q <= 1'b1;
            if (req && state_q == IDLE) begin
                is_wr_q <= req_is_wr;
                addr_q  <= addr;
                data_q  <= wr_data;
                biten_q <= wr_biten;
            end
            // The access itself happens on the edge that leaves ACK.
            if (state_q == ACK) begin
                if (is_wr_q) begin
                    wr_ack_q <= 1'b1;
                    for (int i = 0; i < DEPTH; i++) begin
                        if (wr_ok && idx == IDXW'(i))
                            mem_q[i] <= (mem_q[i] & ~biten_q) | (data_q & biten_q);
                    end
                end else begin
                    rd_ack_q <= 1'b1;
                    if (in_range) rd_data_q <= mem_q[idx];
                end
            end
        end
    end

`ifdef EXTERNAL_BLOCK_MODEL_ERR_EN
    logic rd_err_q, wr_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_err_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            rd_err_q <= (state_q == ACK) && !is_wr_q && !wr_ok;
            wr_err_q <= (state_q == ACK) &&  is_wr_q && !wr_ok;
        end
    end

    assign rd_err = rd_err_q;
    assign wr_err = wr_err_q;
`endif

    assign rd_ack  = rd_ack_q;
    assign wr_ack  = wr_ack_q;
    assign rd_data = rd_data_q;
    assign overrun = overrun_q;

endmodule
